genram_arbiter: RTL

Two-requester arbiter that shares one single-port `genram` instance (synchronous read, 1-cycle latency) between the EdDSA point-arithmetic sequencer (requester 0) and the host/AXI register interface (requester 1). It grants one access per clock using round-robin priority and supports a lock for read-modify-write by requester 0. It routes each read response back to the issuing requester and holds the last read word per requester. It sits between both masters and the RAM and is the only driver of the RAM `wr`/`rd`/`addr`/`data_in` pins.

---
 rtl/genram_arbiter_if.sv | 48 ++++
 rtl/genram_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/genram_arbiter_if.sv
// Request, response and RAM-pin bundle between the two genram masters and the arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters' and RAM's view.
interface genram_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          req0_valid;
  logic          req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_lock;
  logic          req0_ready;

  logic          req1_valid;
  logic          req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req1_ready;

  logic          rsp0_valid;
  logic [DW-1:0] rsp0_data;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_data;

  logic          ram_wr;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata, req0_lock,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  ram_dout,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output ram_wr, ram_rd, ram_addr, ram_din
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, req0_lock,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output ram_dout,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  ram_wr, ram_rd, ram_addr, ram_din
  );
endinterface

// File: rtl/genram_arbiter.sv
// Round-robin arbiter sharing one single-port genram between two masters. It grants in the same cycle.
// Read data arrives one cycle after the grant. A requester that loses waits with valid held; a lock by requester 0 blocks requester 1.
module genram_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  genram_arbiter_if.slave   bus
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_t;

  lock_t         lock_q;
  lock_t         lock_d;
  logic          last;
  logic          pend_rd;
  logic          pend_id;
  logic [DW-1:0] hold0;
  logic [DW-1:0] hold1;

  logic          locked;
  logic          gnt0;
  logic          gnt1;
  logic          gnt_any;
  req_t          req0;
  req_t          req1;
  req_t          sel;
  logic          rsp0_vld;
  logic          rsp1_vld;

  assign locked = (lock_q == LOCKED);
  assign req0   = '{we: bus.req0_we, addr: bus.req0_addr, wdata: bus.req0_wdata};
  assign req1   = '{we: bus.req1_we, addr: bus.req1_addr, wdata: bus.req1_wdata};

  // A tie goes to whichever requester was not granted last. Under lock, only requester 0 is eligible.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (locked) begin
        gnt0 = bus.req0_valid;
      end else if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign gnt_any        = gnt0 | gnt1;
  assign sel            = gnt1 ? req1 : req0;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign bus.ram_addr = sel.addr;
  assign bus.ram_din  = sel.wdata;
  assign bus.ram_wr   = gnt_any & sel.we;
  assign bus.ram_rd   = gnt_any & ~sel.we;

  // Gating with rst drops any read that was granted just before reset.
  assign rsp0_vld       = !rst && pend_rd && !pend_id;
  assign rsp1_vld       = !rst && pend_rd && pend_id;
  assign bus.rsp0_valid = rsp0_vld;
  assign bus.rsp1_valid = rsp1_vld;
  assign bus.rsp0_data  = rsp0_vld ? bus.ram_dout : hold0;
  assign bus.rsp1_data  = rsp1_vld ? bus.ram_dout : hold1;

  always_comb begin
    lock_d = lock_q;
    if (gnt0 && bus.req0_lock) begin
      lock_d = LOCKED;
    end else if (!bus.req0_lock) begin
      lock_d = UNLOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= UNLOCKED;
    end else begin
      lock_q <= lock_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 1'b1;
      pend_rd <= 1'b0;
      pend_id <= 1'b0;
      hold0   <= '0;
      hold1   <= '0;
    end else begin
      if (gnt_any) begin
        last <= gnt1;
      end
      pend_rd <= gnt_any & ~sel.we;
      pend_id <= gnt1;
      if (rsp0_vld) begin
        hold0 <= bus.ram_dout;
      end
      if (rsp1_vld) begin
        hold1 <= bus.ram_dout;
      end
    end
  end

  a_one_grant: assert property (@(posedge clk) !(bus.req0_ready && bus.req1_ready));
  a_wr_rd_excl: assert property (@(posedge clk) !(bus.ram_wr && bus.ram_rd));
  a_rdy_needs_vld: assert property (@(posedge clk)
    (!bus.req0_ready || bus.req0_valid) && (!bus.req1_ready || bus.req1_valid));

endmodule
